// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rr_arbiter
// Brief   : Round-robin packet arbiter that merges NSRC rdy/en streams into one
//           registered output stream. Optional o_id port is enabled by defining
//           FIFO_ARB_SRCID_EN.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter #(
    parameter int NSRC = 4,
    parameter int DW   = 8,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NSRC-1:0]      i_en,
    input  logic [NSRC*DW-1:0]   i_data,
    input  logic [NSRC-1:0]      i_last,
    output logic [NSRC-1:0]      i_rdy,
    input  logic                 o_rdy,
    output logic                 o_en,
    output logic [DW-1:0]        o_data,
    output logic                 o_last
`ifdef FIFO_ARB_SRCID_EN
    ,
    output logic [IDW-1:0]       o_id
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_grant;
    logic [IDW-1:0]   r_rr_ptr;

    logic [NSRC-1:0]  w_sel;
    logic [DW-1:0]    w_gnt_data;
    logic             w_gnt_en;
    logic             w_gnt_last;
    logic             w_out_free;
    logic             w_accept;
    logic             w_any_req;
    logic [IDW-1:0]   w_pick;

    assign w_out_free = ~o_en | o_rdy;
    assign w_any_req  = |i_en;

    always_comb begin : p_grant_mux
        w_sel      = '0;
        w_gnt_data = '0;
        for (int s = 0; s < NSRC; s++) begin
            w_sel[s] = (r_grant == IDW'(s));
            if (w_sel[s]) begin
                w_gnt_data = i_data[s*DW +: DW];
            end
        end
    end

    assign w_gnt_en   = |(i_en & w_sel);
    assign w_gnt_last = |(i_last & w_sel);
    assign i_rdy      = ((r_state == ST_LOCK) && w_out_free) ? w_sel : '0;
    assign w_accept   = (r_state == ST_LOCK) && w_gnt_en && w_out_free;

    // Search starts just after the last packet's owner; indices wrap at NSRC, not 2**IDW.
    always_comb begin : p_rr_search
        logic found;
        found  = 1'b0;
        w_pick = '0;
        for (int k = 1; k <= NSRC; k++) begin
            for (int s = 0; s < NSRC; s++) begin
                if (!found && i_en[s] && (s == ((int'(r_rr_ptr) + k) % NSRC))) begin
                    found  = 1'b1;
                    w_pick = IDW'(s);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= IDW'(NSRC - 1);
            o_en     <= 1'b0;
            o_data   <= '0;
            o_last   <= 1'b0;
        end else begin
            if (w_accept) begin
                o_en   <= 1'b1;
                o_data <= w_gnt_data;
                o_last <= w_gnt_last;
            end else if (w_out_free) begin
                o_en   <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_pick;
                        r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // Grant is held through source gaps until the last beat is taken.
                    if (w_accept && w_gnt_last) begin
                        r_rr_ptr <= r_grant;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_SRCID_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_id <= '0;
        end else if (w_accept) begin
            o_id <= r_grant;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_rr_arbiter
// Brief   : Directed self-checking bench for fifo_rr_arbiter (NSRC=4, DW=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_rr_arbiter;

    localparam int NSRC = 4;
    localparam int DW   = 8;
    localparam int IDW  = 3;

    logic                clk  = 1'b0;
    logic                rstn = 1'b1;
    logic [NSRC-1:0]     i_en   = '0;
    logic [NSRC-1:0]     i_last = '0;
    logic [NSRC*DW-1:0]  i_data = '0;
    logic [NSRC-1:0]     i_rdy;
    logic                o_rdy  = 1'b1;
    logic                o_en;
    logic [DW-1:0]       o_data;
    logic                o_last;
`ifdef FIFO_ARB_SRCID_EN
    logic [IDW-1:0]      o_id;
`endif

    int                  checks = 0;
    int                  errors = 0;
    logic [NSRC-1:0]     xf;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.NSRC(NSRC), .DW(DW), .IDW(IDW)) u_dut (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (i_en),
        .i_data (i_data),
        .i_last (i_last),
        .i_rdy  (i_rdy),
        .o_rdy  (o_rdy),
        .o_en   (o_en),
        .o_data (o_data),
        .o_last (o_last)
`ifdef FIFO_ARB_SRCID_EN
        ,
        .o_id   (o_id)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Record which sources transfer on the coming edge, then land 1 time unit after it.
    task automatic step();
        @(negedge clk);
        xf = i_en & i_rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic en, input logic [DW-1:0] d, input logic l);
        i_en[s]            = en;
        i_data[s*DW +: DW] = d;
        i_last[s]          = l;
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        i_en   = '0;
        i_last = '0;
        i_data = '0;
        o_rdy  = 1'b1;
        step();
        step();
        rstn   = 1'b1;
    endtask

    logic [7:0] exp2 [20] = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'hFF,
                              8'h10, 8'h11, 8'h12, 8'hFF,
                              8'h20, 8'h21, 8'h22, 8'hFF,
                              8'h30, 8'h31, 8'h32, 8'hFF,
                              8'h00, 8'h01, 8'h02};
    int pos [NSRC];
    int pk  [NSRC];

    initial begin
        // Test 1: reset with all sources requesting single-beat packets
        #2;
        rstn = 1'b0;
        for (int s = 0; s < NSRC; s++) set_src(s, 1'b1, 8'(8'h10 + s), 1'b1);
        step();
        check("rst_o_en",   o_en,   1'b0);
        check("rst_o_data", o_data, 8'h00);
        check("rst_o_last", o_last, 1'b0);
        check("rst_i_rdy",  i_rdy,  4'b0000);
        step();
        rstn = 1'b1;
        step();
        check("t1_c1_o_en",  o_en,  1'b0);
        check("t1_c1_rdy",   i_rdy, 4'b0001);
        step();
        check("t1_c2_o_en",  o_en,   1'b1);
        check("t1_c2_data",  o_data, 8'h10);
        check("t1_c2_last",  o_last, 1'b1);
        check("t1_c2_rdy",   i_rdy,  4'b0000);
        step();
        check("t1_bubble",   o_en,   1'b0);
        check("t1_rdy_src1", i_rdy,  4'b0010);
        step();
        check("t1_src1",     o_data, 8'h11);

        // Test 2: every source sends two 3-beat packets
        do_reset();
        for (int s = 0; s < NSRC; s++) begin
            pos[s] = 0;
            pk[s]  = 2;
            set_src(s, 1'b1, 8'(s * 16), 1'b0);
        end
        for (int e = 0; e < 20; e++) begin
            step();
            for (int s = 0; s < NSRC; s++) begin
                if (xf[s]) begin
                    pos[s]++;
                    if (pos[s] == 3) begin
                        pos[s] = 0;
                        pk[s]--;
                    end
                end
                set_src(s, pk[s] > 0, 8'(s * 16 + pos[s]), pos[s] == 2);
            end
            check($sformatf("t2_en_%0d", e + 1), o_en, exp2[e] != 8'hFF);
            if (exp2[e] != 8'hFF) begin
                check($sformatf("t2_data_%0d", e + 1), o_data, exp2[e]);
                check($sformatf("t2_last_%0d", e + 1), o_last, exp2[e][3:0] == 4'd2);
            end
        end

        // Test 3: src2 stalls mid-packet while src1 waits
        do_reset();
        set_src(2, 1'b1, 8'hA0, 1'b0);
        step();
        check("t3_rdy_g2", i_rdy, 4'b0100);
        set_src(1, 1'b1, 8'h51, 1'b1);
        step();
        check("t3_beat_a", o_data, 8'hA0);
        set_src(2, 1'b1, 8'hB0, 1'b0);
        step();
        check("t3_beat_b", o_data, 8'hB0);
        set_src(2, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("t3_stall_en_%0d", c), o_en, 1'b0);
            check($sformatf("t3_stall_rdy_%0d", c), i_rdy, 4'b0100);
        end
        set_src(2, 1'b1, 8'hC0, 1'b1);
        step();
        check("t3_beat_c",   o_data, 8'hC0);
        check("t3_last_c",   o_last, 1'b1);
        set_src(2, 1'b0, 8'h00, 1'b0);
        step();
        check("t3_bubble",   o_en,  1'b0);
        check("t3_rdy_g1",   i_rdy, 4'b0010);
        step();
        check("t3_src1_en",  o_en,   1'b1);
        check("t3_src1",     o_data, 8'h51);

        // Test 4: downstream back-pressure holds the output beat
        do_reset();
        set_src(0, 1'b1, 8'h5A, 1'b0);
        step();
        step();
        set_src(0, 1'b1, 8'h5B, 1'b0);
        o_rdy = 1'b0;
        #1;
        check("t4_rdy_blk", i_rdy, 4'b0000);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("t4_hold_en_%0d", c),   o_en,   1'b1);
            check($sformatf("t4_hold_data_%0d", c), o_data, 8'h5A);
            check($sformatf("t4_hold_rdy_%0d", c),  i_rdy,  4'b0000);
        end
        o_rdy = 1'b1;
        step();
        check("t4_next_data", o_data, 8'h5B);
        set_src(0, 1'b1, 8'h5C, 1'b1);
        step();
        check("t4_last_data", o_data, 8'h5C);
        check("t4_last_flag", o_last, 1'b1);
        set_src(0, 1'b0, 8'h00, 1'b0);

        // Test 5: asynchronous reset mid-packet
        do_reset();
        set_src(3, 1'b1, 8'h30, 1'b0);
        step();
        step();
        check("t5_pre_en",   o_en,   1'b1);
        check("t5_pre_data", o_data, 8'h30);
        rstn = 1'b0;
        #1;
        check("t5_async_en",   o_en,   1'b0);
        check("t5_async_data", o_data, 8'h00);
        set_src(0, 1'b1, 8'h05, 1'b1);
        step();
        step();
        rstn = 1'b1;
        step();
        check("t5_rdy_src0", i_rdy, 4'b0001);
        step();
        check("t5_src0_data", o_data, 8'h05);
        check("t5_src0_last", o_last, 1'b1);

        // Test 6: single-beat packet from src3 only
        do_reset();
        set_src(3, 1'b1, 8'h11, 1'b1);
        step();
        step();
        check("t6_en",   o_en,   1'b1);
        check("t6_data", o_data, 8'h11);
        check("t6_last", o_last, 1'b1);
`ifdef FIFO_ARB_SRCID_EN
        check("t6_id",   o_id,   3'd3);
`endif
        set_src(3, 1'b0, 8'h00, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
